// File: rtl/crossing_scheduler_if.sv
// Lamp, request and state-observation signals between the crossing scheduler
// and its environment. The slave side is the scheduler.
interface crossing_scheduler_if;
  logic       ped_sensor;
  logic       R1;
  logic       Y1;
  logic       G1;
  logic       R2;
  logic       Y2;
  logic       G2;
  logic       ped_wait;
  logic [2:0] present_state;

  modport slave (
    input  ped_sensor,
    output R1, Y1, G1, R2, Y2, G2, ped_wait, present_state
  );

  modport master (
    output ped_sensor,
    input  R1, Y1, G1, R2, Y2, G2, ped_wait, present_state
  );
endinterface

// File: rtl/crossing_scheduler.sv
// Signalised pedestrian crossing: six-state lamp sequencer with a prescaled
// tick timer, a latched pedestrian request and a guaranteed minimum main green.
module crossing_scheduler #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 5,
  parameter int unsigned CLEAR_T   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  crossing_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED1    = 3'd2,
    PED_WALK    = 3'd3,
    PED_CLEAR   = 3'd4,
    ALL_RED2    = 3'd5
  } state_e;

  // Raw 3-bit register so the two unused encodings stay representable.
  logic [2:0] state_q;
  state_e     state_d;
  logic [3:0] prescale_q, prescale_d;
  logic [3:0] timer_q, timer_d;
  logic       req_q, req_d;
  logic       min_done_q, min_done_d;
  logic       tick;
  logic       min_tick;
  logic       changed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= '0;
      prescale_q <= '0;
      timer_q    <= '0;
      req_q      <= 1'b0;
      min_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      timer_q    <= timer_d;
      req_q      <= req_d;
      min_done_q <= min_done_d;
    end
  end

  always_comb begin
    tick     = (prescale_q == 4'(TICK_DIV - 1));
    min_tick = 1'b0;
    state_d  = MAIN_GREEN;
    case (state_q)
      MAIN_GREEN: begin
        min_tick = tick && (timer_q == 4'(MIN_GREEN - 1));
        state_d  = ((min_done_q || min_tick) && req_q) ? MAIN_YELLOW : MAIN_GREEN;
      end
      MAIN_YELLOW: state_d = (tick && timer_q == 4'(YELLOW_T - 1)) ? ALL_RED1  : MAIN_YELLOW;
      ALL_RED1:    state_d = (tick && timer_q == 4'(ALLRED_T - 1)) ? PED_WALK  : ALL_RED1;
      PED_WALK:    state_d = (tick && timer_q == 4'(WALK_T - 1))   ? PED_CLEAR : PED_WALK;
      PED_CLEAR:   state_d = (tick && timer_q == 4'(CLEAR_T - 1))  ? ALL_RED2  : PED_CLEAR;
      ALL_RED2:    state_d = (tick && timer_q == 4'(ALLRED_T - 1)) ? MAIN_GREEN : ALL_RED2;
      default:     state_d = MAIN_GREEN;
    endcase

    changed = (3'(state_d) != state_q);

    // Every state change restarts timing, so N ticks always span N*TICK_DIV cycles.
    prescale_d = '0;
    timer_d    = timer_q;
    if (!changed) begin
      prescale_d = tick ? '0 : prescale_q + 4'd1;
      if (tick) begin
        if (state_q == MAIN_GREEN) begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + 4'd1;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
    end else begin
      timer_d = '0;
    end

    min_done_d = changed ? 1'b0 : (min_tick ? 1'b1 : min_done_q);

    // Entering the walk phase clears the latch even if the button is held.
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      req_d = 1'b0;
    end else if (bus.ped_sensor && state_q != PED_WALK) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
  end

  always_comb begin
    bus.R1 = 1'b0;
    bus.Y1 = 1'b0;
    bus.G1 = 1'b0;
    bus.R2 = 1'b0;
    bus.Y2 = 1'b0;
    bus.G2 = 1'b0;
    case (state_q)
      MAIN_GREEN:  begin bus.G1 = 1'b1; bus.R2 = 1'b1; end
      MAIN_YELLOW: begin bus.Y1 = 1'b1; bus.R2 = 1'b1; end
      PED_WALK:    begin bus.R1 = 1'b1; bus.G2 = 1'b1; end
      PED_CLEAR:   begin bus.R1 = 1'b1; bus.Y2 = 1'b1; end
      default:     begin bus.R1 = 1'b1; bus.R2 = 1'b1; end
    endcase
    bus.ped_wait      = req_q;
    bus.present_state = state_q;
  end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Self-checking bench for crossing_scheduler: directed scenarios plus a
// cycle-count reference model compared on every falling clock edge.
module tb_crossing_scheduler;

  localparam int TD    = 4;
  localparam int MING  = 4;
  localparam int YEL   = 2;
  localparam int ARED  = 1;
  localparam int WALK  = 5;
  localparam int CLR   = 2;
  localparam int MAXW  = 500;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic mon_en;
  logic mon_hold;

  int   m_state;
  int   m_cnt;
  logic m_req;

  crossing_scheduler_if bus_if ();

  crossing_scheduler #(
    .TICK_DIV (TD),
    .MIN_GREEN(MING),
    .YELLOW_T (YEL),
    .ALLRED_T (ARED),
    .WALK_T   (WALK),
    .CLEAR_T  (CLR)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int phase_len(input int s);
    case (s)
      1: return YEL * TD;
      2: return ARED * TD;
      3: return WALK * TD;
      4: return CLR * TD;
      5: return ARED * TD;
      default: return 0;
    endcase
  endfunction

  // Lamps as {R1,Y1,G1,R2,Y2,G2}.
  function automatic logic [5:0] lamps_of(input int s);
    case (s)
      0: return 6'b001_100;
      1: return 6'b010_100;
      3: return 6'b100_001;
      4: return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [5:0] dut_lamps();
    return {bus_if.R1, bus_if.Y1, bus_if.G1, bus_if.R2, bus_if.Y2, bus_if.G2};
  endfunction

  // Reference model: elapsed cycles per phase against duration*TICK_DIV.
  always @(posedge clk or negedge rst_n) begin
    int el;
    int nx;
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_req   <= 1'b0;
    end else if (!mon_hold) begin
      el = m_cnt + 1;
      nx = m_state;
      if (m_state == 0) begin
        if (m_req && el >= MING * TD) nx = 1;
      end else if (el == phase_len(m_state)) begin
        nx = (m_state + 1) % 6;
      end
      if (nx == 3 && m_state != 3) m_req <= 1'b0;
      else if (bus_if.ped_sensor && m_state != 3) m_req <= 1'b1;
      m_cnt   <= (nx != m_state) ? 0 : (el > 100000 ? 100000 : el);
      m_state <= nx;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !mon_hold && rst_n) begin
      n_checks++;
      if (int'(bus_if.present_state) !== m_state || dut_lamps() !== lamps_of(m_state)
          || bus_if.ped_wait !== m_req) begin
        n_fail++;
        $display("FAIL model t=%0t: state=%0d lamps=%b wait=%b expected state=%0d lamps=%b wait=%b",
                 $time, bus_if.present_state, dut_lamps(), bus_if.ped_wait,
                 m_state, lamps_of(m_state), m_req);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (int'(bus_if.R1) + int'(bus_if.Y1) + int'(bus_if.G1) != 1 ||
          int'(bus_if.R2) + int'(bus_if.Y2) + int'(bus_if.G2) != 1) begin
        n_fail++;
        $display("FAIL one_hot t=%0t: lamps=%b expected one main and one ped lamp",
                 $time, dut_lamps());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_change(output int cyc);
    logic [2:0] s0;
    s0  = bus_if.present_state;
    cyc = 0;
    while (bus_if.present_state == s0 && cyc < MAXW) begin
      @(negedge clk);
      cyc++;
    end
    if (bus_if.present_state == s0) cyc = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.present_state !== 3'd0 || dut_lamps() !== 6'b001_100 || bus_if.ped_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d lamps=%b wait=%b expected 0 001100 0",
               bus_if.present_state, dut_lamps(), bus_if.ped_wait);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.present_state !== 3'd0 || bus_if.G1 !== 1'b1 || bus_if.R2 !== 1'b1 ||
          bus_if.ped_wait !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_green cycle %0d: state=%0d G1=%b R2=%b wait=%b expected 0 1 1 0",
                 i, bus_if.present_state, bus_if.G1, bus_if.R2, bus_if.ped_wait);
      end
    end
  endtask

  task automatic test_single_request();
    int c;
    int dur [6];
    dur = '{MING * TD, YEL * TD, ARED * TD, WALK * TD, CLR * TD, ARED * TD};
    do_reset();
    @(negedge clk);
    @(negedge clk);
    bus_if.ped_sensor = 1'b1;
    @(negedge clk);
    bus_if.ped_sensor = 1'b0;
    n_checks++;
    if (bus_if.ped_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait_set: wait=%b expected 1", bus_if.ped_wait);
    end
    for (int i = 0; i < 6; i++) begin
      wait_change(c);
      if (i == 0 && c >= 0) c = c + 3;
      n_checks++;
      if (c !== dur[i] || int'(bus_if.present_state) !== (i + 1) % 6) begin
        n_fail++;
        $display("FAIL single_phase %0d: cycles=%0d next_state=%0d expected %0d %0d",
                 i, c, bus_if.present_state, dur[i], (i + 1) % 6);
      end
      if (i == 2) begin
        n_checks++;
        if (bus_if.ped_wait !== 1'b0 || bus_if.G2 !== 1'b1 || bus_if.R1 !== 1'b1) begin
          n_fail++;
          $display("FAIL walk_entry: wait=%b G2=%b R1=%b expected 0 1 1",
                   bus_if.ped_wait, bus_if.G2, bus_if.R1);
        end
      end
    end
  endtask

  task automatic test_late_request();
    do_reset();
    repeat (39) @(negedge clk);
    bus_if.ped_sensor = 1'b1;
    @(negedge clk);
    bus_if.ped_sensor = 1'b0;
    n_checks++;
    if (bus_if.present_state !== 3'd0 || bus_if.ped_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL late_latch: state=%0d wait=%b expected 0 1", bus_if.present_state, bus_if.ped_wait);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.present_state !== 3'd1) begin
      n_fail++;
      $display("FAIL late_yellow: state=%0d expected 1", bus_if.present_state);
    end
  endtask

  task automatic test_held_button();
    int c;
    bus_if.ped_sensor = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) wait_change(c);
    n_checks++;
    if (bus_if.present_state !== 3'd3 || bus_if.ped_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_walk_entry: state=%0d wait=%b expected 3 0", bus_if.present_state, bus_if.ped_wait);
    end
    repeat (WALK * TD / 2) @(negedge clk);
    n_checks++;
    if (bus_if.present_state !== 3'd3 || bus_if.ped_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_mid_walk: state=%0d wait=%b expected 3 0", bus_if.present_state, bus_if.ped_wait);
    end
    wait_change(c);
    @(negedge clk);
    n_checks++;
    if (bus_if.present_state !== 3'd4 || bus_if.ped_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_rearm_clear: state=%0d wait=%b expected 4 1", bus_if.present_state, bus_if.ped_wait);
    end
    wait_change(c);
    wait_change(c);
    wait_change(c);
    n_checks++;
    if (c !== MING * TD || bus_if.present_state !== 3'd1) begin
      n_fail++;
      $display("FAIL hold_second_green: cycles=%0d state=%0d expected %0d 1",
               c, bus_if.present_state, MING * TD);
    end
    bus_if.ped_sensor = 1'b0;
  endtask

  task automatic test_reset_mid_walk();
    int c;
    do_reset();
    bus_if.ped_sensor = 1'b1;
    @(negedge clk);
    bus_if.ped_sensor = 1'b0;
    for (int i = 0; i < 4 && bus_if.present_state != 3'd3; i++) wait_change(c);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.present_state !== 3'd0 || dut_lamps() !== 6'b001_100 || bus_if.ped_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: state=%0d lamps=%b wait=%b expected 0 001100 0",
               bus_if.present_state, dut_lamps(), bus_if.ped_wait);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.ped_sensor = 1'b1;
    @(negedge clk);
    bus_if.ped_sensor = 1'b0;
    wait_change(c);
    if (c >= 0) c = c + 1;
    n_checks++;
    if (c !== MING * TD || bus_if.present_state !== 3'd1) begin
      n_fail++;
      $display("FAIL post_abort_green: cycles=%0d state=%0d expected %0d 1",
               c, bus_if.present_state, MING * TD);
    end
  endtask

  task automatic test_illegal_state();
    int c;
    do_reset();
    repeat (5) @(negedge clk);
    mon_hold = 1'b1;
    force dut.state_q = 3'd6;
    #1;
    n_checks++;
    if (bus_if.present_state !== 3'd6 || dut_lamps() !== 6'b100_100) begin
      n_fail++;
      $display("FAIL illegal_decode: state=%0d lamps=%b expected 6 100100",
               bus_if.present_state, dut_lamps());
    end
    release dut.state_q;
    @(negedge clk);
    n_checks++;
    if (bus_if.present_state !== 3'd0) begin
      n_fail++;
      $display("FAIL illegal_recover: state=%0d expected 0", bus_if.present_state);
    end
    m_state <= 0;
    m_cnt   <= 0;
    m_req   <= 1'b0;
    bus_if.ped_sensor = 1'b1;
    #1;
    mon_hold = 1'b0;
    @(negedge clk);
    bus_if.ped_sensor = 1'b0;
    wait_change(c);
    if (c >= 0) c = c + 1;
    n_checks++;
    if (c !== MING * TD || bus_if.present_state !== 3'd1) begin
      n_fail++;
      $display("FAIL illegal_then_green: cycles=%0d state=%0d expected %0d 1",
               c, bus_if.present_state, MING * TD);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus_if.ped_sensor = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) bus_if.ped_sensor = 1'b1;
    end
    bus_if.ped_sensor = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    mon_hold = 1'b0;
    rst_n    = 1'b1;
    bus_if.ped_sensor = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    mon_en = 1'b1;
    test_reset();
    test_single_request();
    test_late_request();
    test_held_button();
    test_reset_mid_walk();
    test_illegal_state();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
